// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: master FSM states, ACK status codes, TM encodings.
package nubus_pkg;

    // Master sequencer states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_ATTN = 3'd4
    } mst_state_e;

    // ACK status codes as sampled on TM1/TM0 (active-high), also reported to the CPU
    localparam logic [1:0] ST_COMPLETE = 2'b00;
    localparam logic [1:0] ST_ERROR    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_RETRY    = 2'b11;

    // Inverted TM lines when the master is not driving an address-cycle mode
    localparam logic [1:0] TM_N_IDLE = 2'b11;

    // Active-high transfer mode to the inverted form the driver expects
    function automatic logic [1:0] tm_to_n(input logic [1:0] tm);
        return ~tm;
    endfunction

endpackage

// File: rtl/nubus_timeout_cnt.sv
// Loadable saturating down-counter with an expiry flag.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_load           load i_load_val (has priority over counting)
//   i_load_val       value loaded into the counter
//   i_en             decrement by one; holds at zero, never wraps
//   o_expired_c      counter is zero (combinational from the count register)
module nubus_timeout_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired_c
);

    logic [W-1:0] r_cnt;

    // Count register: load, else saturating decrement
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/nubus_master_ctrl.sv
// NuBus master transaction sequencer: arbitration, address, data/wait-for-ACK
// and locked-sequence NULL-ATTN, with ACK status decode, try-again retry and
// a local bus timeout.
// Ports:
//   nub_clkn, nub_reset          clock, synchronous active-high reset
//   cpu_valid/cpu_tm/cpu_lock    local transfer request
//   nub_grant/start/ack/tm       sampled bus and arbitration inputs
//   mst_*                        registered cycle flags for the NuBus driver
//   cpu_done/cpu_status          one-clock completion pulse with final status
module nubus_master_ctrl
    import nubus_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic       nub_clkn,
    input  logic       nub_reset,
    input  logic       cpu_valid,
    input  logic [1:0] cpu_tm,
    input  logic       cpu_lock,
    input  logic       nub_grant,
    input  logic       nub_start,
    input  logic       nub_ack,
    input  logic [1:0] nub_tm,
    output logic       mst_arbcy,
    output logic       mst_adrcy,
    output logic       mst_dtacy,
    output logic       mst_owner,
    output logic       mst_locked,
    output logic       mst_tm1n,
    output logic       mst_tm0n,
    output logic       cpu_done,
    output logic [1:0] cpu_status
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam int unsigned RET_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    mst_state_e       r_state;
    logic             r_owner;
    logic             r_arbcy;
    logic             r_adrcy;
    logic             r_dtacy;
    logic             r_locked;
    logic [1:0]       r_tm_n;
    logic             r_done;
    logic [1:0]       r_status;
    logic             r_busy;
    logic [1:0]       r_tm_lat;
    logic             r_lock_lat;
    logic             r_seq;
    logic [RET_W-1:0] r_retry;

    mst_state_e       w_state_nxt;
    logic             w_owner_nxt;
    logic             w_arbcy_nxt;
    logic             w_adrcy_nxt;
    logic             w_dtacy_nxt;
    logic             w_locked_nxt;
    logic [1:0]       w_tm_n_nxt;
    logic             w_done_nxt;
    logic [1:0]       w_status_nxt;
    logic             w_busy_nxt;
    logic [1:0]       w_tm_lat_nxt;
    logic             w_lock_lat_nxt;
    logic             w_seq_nxt;
    logic [RET_W-1:0] w_retry_nxt;
    logic             w_busy_eff;
    logic             w_finish;
    logic [1:0]       w_fin_status;
    logic             w_cnt_load;
    logic             w_cnt_en;
    logic             w_expired;

    // DATA-phase ACK timeout; loaded during ADDR so it expires on the TIMEOUT-th DATA clock
    nubus_timeout_cnt #(
        .W (CNT_W)
    ) u_tmo (
        .i_clk       (nub_clkn),
        .i_rst       (nub_reset),
        .i_load      (w_cnt_load),
        .i_load_val  (CNT_W'(TIMEOUT - 1)),
        .i_en        (w_cnt_en),
        .o_expired_c (w_expired)
    );

    // Another master's transaction is open; an ACK this clock ends it immediately
    assign w_busy_eff = r_busy & ~nub_ack;
    // A START wins over a coincident ACK: it opens the next transaction
    assign w_busy_nxt = (nub_start && !r_owner) ? 1'b1 : (nub_ack ? 1'b0 : r_busy);

    // Next state, bookkeeping and next registered outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_tm_lat_nxt   = r_tm_lat;
        w_lock_lat_nxt = r_lock_lat;
        w_seq_nxt      = r_seq;
        w_retry_nxt    = r_retry;
        w_done_nxt     = 1'b0;
        w_status_nxt   = r_status;
        w_cnt_load     = 1'b0;
        w_cnt_en       = 1'b0;
        w_finish       = 1'b0;
        w_fin_status   = ST_COMPLETE;

        case (r_state)
            S_IDLE: begin
                if (r_owner) begin
                    // Holding the bus after a locked transfer
                    if (cpu_valid && r_lock_lat) begin
                        w_state_nxt    = S_ADDR;
                        w_tm_lat_nxt   = cpu_tm;
                        w_lock_lat_nxt = cpu_lock;
                        w_retry_nxt    = '0;
                        w_seq_nxt      = 1'b1;
                    end else begin
                        w_state_nxt = S_ATTN;
                    end
                end else if (cpu_valid) begin
                    w_state_nxt    = S_ARB;
                    w_tm_lat_nxt   = cpu_tm;
                    w_lock_lat_nxt = cpu_lock;
                    w_retry_nxt    = '0;
                    w_seq_nxt      = 1'b0;
                end
            end
            S_ARB: begin
                if (nub_grant && !w_busy_eff && !nub_start) begin
                    w_state_nxt = S_ADDR;
                    w_owner_nxt = 1'b1;
                end
            end
            S_ADDR: begin
                w_state_nxt = S_DATA;
                w_cnt_load  = 1'b1;
            end
            S_DATA: begin
                w_cnt_en = 1'b1;
                if (nub_ack) begin
                    if ((nub_tm == ST_RETRY) && (r_retry < RET_W'(RETRY_MAX))) begin
                        w_retry_nxt = r_retry + RET_W'(1);
                        w_owner_nxt = 1'b0;
                        w_seq_nxt   = 1'b0;
                        w_state_nxt = S_ARB;
                    end else begin
                        w_finish     = 1'b1;
                        w_fin_status = nub_tm;
                    end
                end else if (w_expired) begin
                    w_finish     = 1'b1;
                    w_fin_status = ST_TIMEOUT;
                end
            end
            S_ATTN: begin
                w_state_nxt    = S_IDLE;
                w_owner_nxt    = 1'b0;
                w_seq_nxt      = 1'b0;
                w_lock_lat_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_owner_nxt = 1'b0;
            end
        endcase

        // Completion: keep the bus only for a clean transfer inside a locked sequence
        if (w_finish) begin
            w_done_nxt   = 1'b1;
            w_status_nxt = w_fin_status;
            w_state_nxt  = S_IDLE;
            if (!((w_fin_status == ST_COMPLETE) && (r_lock_lat || r_seq))) begin
                w_owner_nxt = 1'b0;
            end
        end

        // Cycle flags follow the state being entered so they line up with it
        w_arbcy_nxt  = (w_state_nxt == S_ARB) || (w_state_nxt == S_ATTN);
        w_adrcy_nxt  = (w_state_nxt == S_ADDR);
        w_dtacy_nxt  = (w_state_nxt == S_ADDR) || (w_state_nxt == S_ATTN);
        w_tm_n_nxt   = (w_state_nxt == S_ADDR) ? tm_to_n(w_tm_lat_nxt) : TM_N_IDLE;
        w_locked_nxt = w_owner_nxt && w_lock_lat_nxt && (w_state_nxt != S_ATTN);
    end

    // State and output registers
    always_ff @(posedge nub_clkn) begin
        if (nub_reset) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_arbcy    <= 1'b0;
            r_adrcy    <= 1'b0;
            r_dtacy    <= 1'b0;
            r_locked   <= 1'b0;
            r_tm_n     <= TM_N_IDLE;
            r_done     <= 1'b0;
            r_status   <= ST_COMPLETE;
            r_busy     <= 1'b0;
            r_tm_lat   <= 2'b00;
            r_lock_lat <= 1'b0;
            r_seq      <= 1'b0;
            r_retry    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_arbcy    <= w_arbcy_nxt;
            r_adrcy    <= w_adrcy_nxt;
            r_dtacy    <= w_dtacy_nxt;
            r_locked   <= w_locked_nxt;
            r_tm_n     <= w_tm_n_nxt;
            r_done     <= w_done_nxt;
            r_status   <= w_status_nxt;
            r_busy     <= w_busy_nxt;
            r_tm_lat   <= w_tm_lat_nxt;
            r_lock_lat <= w_lock_lat_nxt;
            r_seq      <= w_seq_nxt;
            r_retry    <= w_retry_nxt;
        end
    end

    assign mst_arbcy  = r_arbcy;
    assign mst_adrcy  = r_adrcy;
    assign mst_dtacy  = r_dtacy;
    assign mst_owner  = r_owner;
    assign mst_locked = r_locked;
    assign mst_tm1n   = r_tm_n[1];
    assign mst_tm0n   = r_tm_n[0];
    assign cpu_done   = r_done;
    assign cpu_status = r_status;

endmodule

// File: tb/tb_nubus_master_ctrl.sv
// Bench for nubus_master_ctrl: directed stimulus with a completion scoreboard.
// Flag vector order: {arbcy, adrcy, dtacy, owner, locked, tm1n, tm0n}.
module tb_nubus_master_ctrl;
    import nubus_pkg::*;

    localparam int unsigned TIMEOUT   = 255;
    localparam int unsigned RETRY_MAX = 3;

    logic       nub_clkn = 1'b0;
    logic       nub_reset;
    logic       cpu_valid;
    logic [1:0] cpu_tm;
    logic       cpu_lock;
    logic       nub_grant;
    logic       nub_start;
    logic       nub_ack;
    logic [1:0] nub_tm;
    logic       mst_arbcy, mst_adrcy, mst_dtacy, mst_owner, mst_locked;
    logic       mst_tm1n, mst_tm0n;
    logic       cpu_done;
    logic [1:0] cpu_status;
    logic [6:0] flags;

    typedef struct {
        logic [1:0]  st;
        int unsigned cyc;
        logic        own;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int unsigned cyc = 0;
    int unsigned a;
    int          n_checks = 0;
    int          n_fail   = 0;

    nubus_master_ctrl #(
        .TIMEOUT   (TIMEOUT),
        .RETRY_MAX (RETRY_MAX)
    ) dut (
        .nub_clkn   (nub_clkn),
        .nub_reset  (nub_reset),
        .cpu_valid  (cpu_valid),
        .cpu_tm     (cpu_tm),
        .cpu_lock   (cpu_lock),
        .nub_grant  (nub_grant),
        .nub_start  (nub_start),
        .nub_ack    (nub_ack),
        .nub_tm     (nub_tm),
        .mst_arbcy  (mst_arbcy),
        .mst_adrcy  (mst_adrcy),
        .mst_dtacy  (mst_dtacy),
        .mst_owner  (mst_owner),
        .mst_locked (mst_locked),
        .mst_tm1n   (mst_tm1n),
        .mst_tm0n   (mst_tm0n),
        .cpu_done   (cpu_done),
        .cpu_status (cpu_status)
    );

    assign flags = {mst_arbcy, mst_adrcy, mst_dtacy, mst_owner, mst_locked, mst_tm1n, mst_tm0n};

    always #5 nub_clkn = ~nub_clkn;
    always @(posedge nub_clkn) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_flags(input string name, input logic [6:0] exp);
        chk(name, 32'(flags), 32'(exp));
    endtask

    task automatic tick();
        @(negedge nub_clkn);
    endtask

    task automatic expect_done(input logic [1:0] st, input int unsigned c, input logic own);
        q.push_back('{st, c, own});
    endtask

    // Hold ACK off for n-1 DATA clocks, then present it with status st for one clock
    task automatic do_ack(input int n, input logic [1:0] st);
        for (int i = 1; i < n; i++) tick();
        nub_ack = 1'b1;
        nub_tm  = st;
        tick();
        nub_ack = 1'b0;
        nub_tm  = 2'b00;
    endtask

    // Completion monitor: every cpu_done pulse must match the next expected entry
    always @(negedge nub_clkn) begin
        if (cpu_done) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got status %0h at cycle %0d, expected no completion",
                         cpu_status, cyc);
            end else begin
                m_e = q.pop_front();
                chk("done_status", 32'(cpu_status), 32'(m_e.st));
                chk("done_cycle", cyc, m_e.cyc);
                chk("done_owner", 32'(mst_owner), 32'(m_e.own));
            end
        end
    end

    initial begin
        nub_reset = 1'b1;
        cpu_valid = 1'b0;
        cpu_tm    = 2'b00;
        cpu_lock  = 1'b0;
        nub_grant = 1'b0;
        nub_start = 1'b0;
        nub_ack   = 1'b0;
        nub_tm    = 2'b00;
        tick();
        tick();
        chk_flags("reset_flags", 7'b0000011);
        chk("reset_done", 32'(cpu_done), 32'(0));
        chk("reset_status", 32'(cpu_status), 32'(0));
        nub_reset = 1'b0;
        tick();

        // Unlocked write, immediate grant, ACK 00 on the third DATA clock
        cpu_valid = 1'b1; cpu_tm = 2'b01; cpu_lock = 1'b0; nub_grant = 1'b1;
        tick(); chk_flags("wr_arb", 7'b1000011);
        tick(); chk_flags("wr_addr", 7'b0111010);
        a = cyc; expect_done(ST_COMPLETE, a + 4, 1'b0);
        tick(); chk_flags("wr_data", 7'b0001011);
        do_ack(3, ST_COMPLETE);
        cpu_valid = 1'b0;
        chk_flags("wr_idle", 7'b0000011);
        tick();

        // Busy bus: foreign START holds ARB until its ACK
        cpu_valid = 1'b1; cpu_tm = 2'b10; nub_start = 1'b1;
        tick(); nub_start = 1'b0; chk_flags("busy_arb0", 7'b1000011);
        tick(); chk_flags("busy_arb1", 7'b1000011);
        tick(); chk_flags("busy_arb2", 7'b1000011);
        nub_ack = 1'b1;
        tick(); nub_ack = 1'b0; chk_flags("busy_addr", 7'b0111001);
        a = cyc; expect_done(ST_ERROR, a + 2, 1'b0);
        tick();
        do_ack(1, ST_ERROR);
        cpu_valid = 1'b0;
        tick();

        // Try-again four times: three re-arbitrations, then retries exhausted
        cpu_valid = 1'b1; cpu_tm = 2'b00;
        tick(); chk_flags("retry_arb", 7'b1000011);
        for (int r = 0; r < 4; r++) begin
            tick(); chk_flags("retry_addr", 7'b0111011);
            a = cyc;
            tick();
            if (r < 3) begin
                do_ack(1, ST_RETRY);
                chk_flags("retry_rearb", 7'b1000011);
            end else begin
                expect_done(ST_RETRY, a + 2, 1'b0);
                do_ack(1, ST_RETRY);
            end
        end
        cpu_valid = 1'b0;
        tick();

        // Reset while in DATA: everything back to reset values, no completion
        cpu_valid = 1'b1; cpu_tm = 2'b01;
        tick(); tick(); tick(); chk_flags("rst_pre", 7'b0001011);
        nub_reset = 1'b1;
        tick();
        chk_flags("rst_flags", 7'b0000011);
        chk("rst_done", 32'(cpu_done), 32'(0));
        chk("rst_status", 32'(cpu_status), 32'(0));
        cpu_valid = 1'b0; nub_reset = 1'b0;
        tick();
        chk_flags("rst_idle", 7'b0000011);
        chk("rst_done2", 32'(cpu_done), 32'(0));

        // Timeout: no ACK, completion TIMEOUT clocks after the ADDR clock
        cpu_valid = 1'b1; cpu_tm = 2'b01;
        tick(); tick();
        a = cyc; expect_done(ST_TIMEOUT, a + 1 + TIMEOUT, 1'b0);
        tick();
        repeat (TIMEOUT) tick();
        cpu_valid = 1'b0;
        chk_flags("tmo_idle", 7'b0000011);
        tick();

        // ACK on the expiry clock wins over the timeout
        cpu_valid = 1'b1; cpu_tm = 2'b01;
        tick(); tick();
        a = cyc; expect_done(ST_COMPLETE, a + 1 + TIMEOUT, 1'b0);
        tick();
        do_ack(TIMEOUT, ST_COMPLETE);
        cpu_valid = 1'b0;
        tick();

        // Locked pair: second goes straight to ADDR, then one NULL-ATTN clock
        cpu_valid = 1'b1; cpu_tm = 2'b11; cpu_lock = 1'b1;
        tick(); chk_flags("lk_arb", 7'b1000011);
        tick(); chk_flags("lk_addr1", 7'b0111100);
        a = cyc; expect_done(ST_COMPLETE, a + 3, 1'b1);
        tick(); chk_flags("lk_data1", 7'b0001111);
        do_ack(2, ST_COMPLETE);
        chk_flags("lk_hold1", 7'b0001111);
        cpu_tm = 2'b01; nub_grant = 1'b0;
        tick(); chk_flags("lk_addr2", 7'b0111110);
        a = cyc; expect_done(ST_COMPLETE, a + 2, 1'b1);
        tick();
        do_ack(1, ST_COMPLETE);
        cpu_valid = 1'b0; cpu_lock = 1'b0;
        chk_flags("lk_hold2", 7'b0001111);
        tick(); chk_flags("lk_attn", 7'b1011011);
        tick(); chk_flags("lk_release", 7'b0000011);

        // Unlocked request inside a locked sequence: performed, then ATTN
        cpu_valid = 1'b1; cpu_tm = 2'b10; cpu_lock = 1'b1; nub_grant = 1'b1;
        tick(); tick(); chk_flags("mix_addr1", 7'b0111101);
        a = cyc; expect_done(ST_COMPLETE, a + 2, 1'b1);
        tick();
        do_ack(1, ST_COMPLETE);
        cpu_tm = 2'b00; cpu_lock = 1'b0; nub_grant = 1'b0;
        tick(); chk_flags("mix_addr2", 7'b0111011);
        a = cyc; expect_done(ST_COMPLETE, a + 2, 1'b1);
        tick(); chk_flags("mix_data2", 7'b0001011);
        do_ack(1, ST_COMPLETE);
        cpu_valid = 1'b0;
        chk_flags("mix_hold", 7'b0001011);
        tick(); chk_flags("mix_attn", 7'b1011011);
        tick(); chk_flags("mix_release", 7'b0000011);

        tick();
        tick();
        chk("sb_empty", 32'(q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
